// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-tick generator: integer down-counter plus a phase accumulator
// that inserts one stretch cycle on each accumulator carry; emits oversample/xmit/sample pulses.
module uart_baud_gen_frac #(
  parameter int CNTR_W   = 13,
  parameter int FRAC_W   = 3,
  parameter int OVS_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                reload,
  input  logic [CNTR_W-1:0]   baud_val,
  input  logic [FRAC_W-1:0]   baud_frac,
  output logic                baud_clock,
  output logic                xmit_pulse,
  output logic                sample_pulse,
  output logic [OVS_LOG2-1:0] tick_cnt
);

  localparam logic [OVS_LOG2-1:0] TICK_LAST = {OVS_LOG2{1'b1}};
  localparam logic [OVS_LOG2-1:0] TICK_HALF = OVS_LOG2'((1 << OVS_LOG2) / 2 - 1);

  logic [CNTR_W-1:0]   cnt_q, cnt_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic                stretch_q, stretch_d;
  logic [OVS_LOG2-1:0] tick_q, tick_d;
  logic                baud_q, baud_d;
  logic                xmit_q, xmit_d;
  logic                sample_q, sample_d;
  logic [FRAC_W:0]     acc_sum;

  // Carry out of the fractional add requests one extra cycle before the next tick.
  assign acc_sum = {1'b0, acc_q} + {1'b0, baud_frac};

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    stretch_d = stretch_q;
    tick_d    = tick_q;
    baud_d    = 1'b0;
    xmit_d    = 1'b0;
    sample_d  = 1'b0;
    if (reload) begin
      cnt_d     = baud_val;
      acc_d     = '0;
      stretch_d = 1'b0;
      tick_d    = '0;
    end else if (enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNTR_W'(1);
      end else if (stretch_q) begin
        stretch_d = 1'b0;
      end else begin
        cnt_d     = baud_val;
        baud_d    = 1'b1;
        acc_d     = acc_sum[FRAC_W-1:0];
        stretch_d = acc_sum[FRAC_W];
        tick_d    = tick_q + OVS_LOG2'(1);
        xmit_d    = (tick_q == TICK_LAST);
        sample_d  = (tick_q == TICK_HALF);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      stretch_q <= 1'b0;
      tick_q    <= '0;
      baud_q    <= 1'b0;
      xmit_q    <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
      tick_q    <= tick_d;
      baud_q    <= baud_d;
      xmit_q    <= xmit_d;
      sample_q  <= sample_d;
    end
  end

  assign baud_clock   = baud_q;
  assign xmit_pulse   = xmit_q;
  assign sample_pulse = sample_q;
  assign tick_cnt     = tick_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench: stimulus pushes expected tick records (cycle, phase, pulses) for a
// 16x and a 4x instance sharing inputs; a negedge monitor pops and compares on each tick.
module tb_uart_baud_gen_frac;

  logic        clk, reset_n, enable, reload;
  logic [12:0] baud_val;
  logic [2:0]  baud_frac;
  logic        b0, x0, s0, b1, x1, s1;
  logic [3:0]  tc0;
  logic [1:0]  tc1;

  uart_baud_gen_frac #(.CNTR_W(13), .FRAC_W(3), .OVS_LOG2(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .reload(reload),
    .baud_val(baud_val), .baud_frac(baud_frac),
    .baud_clock(b0), .xmit_pulse(x0), .sample_pulse(s0), .tick_cnt(tc0));

  uart_baud_gen_frac #(.CNTR_W(13), .FRAC_W(3), .OVS_LOG2(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .reload(reload),
    .baud_val(baud_val), .baud_frac(baud_frac),
    .baud_clock(b1), .xmit_pulse(x1), .sample_pulse(s1), .tick_cnt(tc1));

  typedef struct {
    int c;
    int tc0, x0, s0;
    int tc1, x1, s1;
  } rec_t;

  rec_t exp_q[$];
  int   seen_t[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // t = ticks since reset/reload; tick phase reads t mod OVS on each instance
  task automatic push(input int c, input int t);
    rec_t r;
    r.c = c;
    r.tc0 = t % 16; r.x0 = (r.tc0 == 0); r.s0 = (r.tc0 == 8);
    r.tc1 = t % 4;  r.x1 = (r.tc1 == 0); r.s1 = (r.tc1 == 2);
    exp_q.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // wait for the last expected tick, freeze the generator, then require an empty scoreboard
  task automatic drain(input int upto);
    while (cyc < upto) step(1);
    enable = 1'b0;
    @(negedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic restart(input int bv, input int bf);
    baud_val  = 13'(bv);
    baud_frac = 3'(bf);
    reload = 1'b1; enable = 1'b1;
    step(1);
    reload = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (b0) begin
        seen_t.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          if (r.c != cyc || r.tc0 != int'(tc0) || r.x0 != int'(x0) || r.s0 != int'(s0) ||
              b1 !== 1'b1 || r.tc1 != int'(tc1) || r.x1 != int'(x1) || r.s1 != int'(s1)) begin
            n_fail++;
            $display("FAIL tick: got cyc=%0d tc=%0d x=%0d s=%0d | b1=%0d tc1=%0d x1=%0d s1=%0d ; expected cyc=%0d tc=%0d x=%0d s=%0d | b1=1 tc1=%0d x1=%0d s1=%0d",
                     cyc, tc0, x0, s0, b1, tc1, x1, s1, r.c, r.tc0, r.x0, r.s0, r.tc1, r.x1, r.s1);
          end
        end
      end else if (x0 || s0 || b1 || x1 || s1) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_pulse: x=%0d s=%0d b1=%0d x1=%0d s1=%0d at cycle %0d with no tick, expected all 0",
                 x0, s0, b1, x1, s1, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int k, c;
    reset_n = 1'b0; enable = 1'b0; reload = 1'b0;
    baud_val = 13'd3; baud_frac = 3'd0;
    step(2);
    chk("rst_baud", int'(b0), 0);
    chk("rst_xmit", int'(x0), 0);
    chk("rst_sample", int'(s0), 0);
    chk("rst_tick_cnt", int'(tc0), 0);

    // integer divide by 4; first tick on the first enabled edge after reset release
    reset_n = 1'b1; enable = 1'b1;
    k = cyc;
    for (int i = 0; i < 40; i++) push(k + 1 + 4 * i, i + 1);
    drain(k + 1 + 4 * 39);

    // 3 + 4/8: periods 4,5,4,5...; 16 intervals span 72 cycles
    seen_t.delete();
    restart(3, 4);
    k = cyc; c = k + 4;
    for (int j = 1; j <= 17; j++) begin push(c, j); c += (j % 2 == 1) ? 4 : 5; end
    drain(k + 4 + 72);
    chk("half_ticks", seen_t.size(), 17);
    if (seen_t.size() >= 17) chk("half_span", seen_t[16] - seen_t[0], 72);

    // 3 + 7/8: periods 4,5,5,5,5,5,5,5; 8 intervals span 39 cycles
    seen_t.delete();
    restart(3, 7);
    k = cyc; c = k + 4;
    for (int j = 1; j <= 9; j++) begin push(c, j); c += (j % 8 == 1) ? 4 : 5; end
    drain(k + 4 + 39);
    chk("frac78_ticks", seen_t.size(), 9);
    if (seen_t.size() >= 9) chk("frac78_span", seen_t[8] - seen_t[0], 39);

    // max rate: tick every enabled cycle
    restart(0, 0);
    k = cyc;
    for (int j = 1; j <= 12; j++) push(k + j, j);
    drain(k + 12);

    // 10-cycle hold after tick 3 shifts later ticks by exactly 10, accumulator preserved
    restart(3, 4);
    k = cyc;
    push(k + 4, 1); push(k + 8, 2); push(k + 13, 3);
    push(k + 27, 4); push(k + 32, 5); push(k + 36, 6); push(k + 41, 7);
    step(14);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_tick_cnt", int'(tc0), 3);
      chk("hold_baud", int'(b0), 0);
    end
    enable = 1'b1;
    drain(k + 41);

    // reload while disabled still restarts; tick_cnt and acc return to 0
    reload = 1'b1;
    step(1);
    reload = 1'b0;
    k = cyc;
    chk("reload_dis_tick_cnt", int'(tc0), 0);
    step(3);
    enable = 1'b1;
    push(k + 7, 1); push(k + 11, 2);
    drain(k + 11);

    // async reset between edges while the stretch cycle is pending
    restart(3, 4);
    k = cyc;
    push(k + 4, 1); push(k + 8, 2);
    step(11);
    chk("pre_rst_tick_cnt", int'(tc0), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tick_cnt", int'(tc0), 0);
    chk("arst_tick_cnt_4x", int'(tc1), 0);
    chk("arst_baud", int'(b0), 0);
    chk("arst_xmit", int'(x0), 0);
    chk("arst_sample", int'(s0), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    k = cyc;
    push(k + 1, 1);
    drain(k + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
